// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the segment-scan capture block.
// Holds the FSM state encoding and the one-hot select check.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_TMO     = 2'd3
    } state_t;

    // Select buses are zero-extended to 16 bits before the check, so up to 16 digits are supported
    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/seg_scan_slot.sv
// One digit slot: capture flag plus pattern register. A write lands in the slot one cycle after wr; there is no backpressure.
// With SEG_SCAN_STABLE_EN, a pattern is taken only after two consecutive equal selects.
module seg_scan_slot #(
    parameter int SEG_W = 8
) (
    input  logic             I_sys_clk,
    input  logic             I_rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [SEG_W-1:0] seg,
    output logic             take,
    output logic             captured,
    output logic [SEG_W-1:0] pattern
);

`ifdef SEG_SCAN_STABLE_EN
    logic [SEG_W-1:0] cand;
    logic             cand_vld;

    assign take = wr && !captured && cand_vld && (cand == seg);

    // A mismatching select replaces the candidate and restarts the match
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cand     <= '0;
            cand_vld <= 1'b0;
        end else if (clr) begin
            cand     <= '0;
            cand_vld <= 1'b0;
        end else if (wr && !captured && !take) begin
            cand     <= seg;
            cand_vld <= 1'b1;
        end
    end
`else
    assign take = wr && !captured;
`endif

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            captured <= 1'b0;
            pattern  <= '0;
        end else if (clr) begin
            captured <= 1'b0;
            pattern  <= '0;
        end else if (take) begin
            captured <= 1'b1;
            pattern  <= seg;
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures scanned 7-seg digit patterns after a start edge. Start acts 2 cycles after I_start rises; there is no backpressure.
// The optional build macro SEG_SCAN_STABLE_EN requires two matching selects per digit.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int SEG_W  = 8,
    parameter int DATA_W = 16,
    parameter int TO_W   = 24
) (
    input  logic                    I_sys_clk,
    input  logic                    I_rst_n,
    input  logic                    I_start,
    input  logic                    I_test_en,
    input  logic [DIGITS-1:0]       I_test_sel,
    input  logic [SEG_W-1:0]        I_test_seg,
    input  logic [DATA_W-1:0]       I_test_disp_data,
    input  logic [TO_W-1:0]         I_timeout,
    output logic [DIGITS*SEG_W-1:0] O_seg_data,
    output logic [DATA_W-1:0]       O_disp_data,
    output logic [DIGITS-1:0]       O_cap_mask,
    output logic                    O_busy,
    output logic                    O_done,
    output logic                    O_timeout,
    output logic                    O_sel_err
);

    state_t            state;
    logic [1:0]        start_sh;
    logic [TO_W-1:0]   cnt;
    logic [DATA_W-1:0] disp;
    logic              sel_err;
    logic              start_pulse;
    logic              clr;
    logic              cap_en;
    logic              sel_one;
    logic              sel_multi;
    logic              mask_full;
    logic              mask_next_full;
    logic              to_hit;
    logic [DIGITS-1:0] take;
    logic [15:0]       sel_ext;

    assign sel_ext        = 16'(I_test_sel);
    assign sel_one        = is_onehot(sel_ext);
    assign sel_multi      = (I_test_sel != '0) && !sel_one;
    assign start_pulse    = (start_sh == 2'b01);
    assign clr            = !I_test_en || start_pulse;
    assign cap_en         = I_test_en && !start_pulse && (state == ST_CAPTURE);
    assign mask_full      = &O_cap_mask;
    assign mask_next_full = &(O_cap_mask | take);
    assign to_hit         = (I_timeout != '0) && (cnt == I_timeout - TO_W'(1));

    for (genvar k = 0; k < DIGITS; k++) begin : g_slot
        seg_scan_slot #(.SEG_W(SEG_W)) u_slot (
            .I_sys_clk (I_sys_clk),
            .I_rst_n   (I_rst_n),
            .clr       (clr),
            .wr        (cap_en && sel_one && I_test_sel[k]),
            .seg       (I_test_seg),
            .take      (take[k]),
            .captured  (O_cap_mask[k]),
            .pattern   (O_seg_data[k*SEG_W +: SEG_W])
        );
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            start_sh <= 2'b00;
        end else begin
            start_sh <= {start_sh[0], I_start};
        end
    end

    // Priority: enable low, then restart, then completion, then timeout
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            disp    <= '0;
            sel_err <= 1'b0;
        end else if (!I_test_en) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            disp    <= '0;
            sel_err <= 1'b0;
        end else if (start_pulse) begin
            state   <= ST_CAPTURE;
            cnt     <= '0;
            disp    <= '0;
            sel_err <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            if (sel_multi) begin
                sel_err <= 1'b1;
            end
            if (take[0]) begin
                disp <= I_test_disp_data;
            end
            // A digit set completing on the timeout cycle still finishes as done
            if (mask_full) begin
                state <= ST_DONE;
            end else if (to_hit && !mask_next_full) begin
                state <= ST_TMO;
            end else if (cnt != {TO_W{1'b1}}) begin
                cnt <= cnt + TO_W'(1);
            end
        end
    end

    assign O_disp_data = disp;
    assign O_sel_err   = sel_err;
    assign O_busy      = (state == ST_CAPTURE);
    assign O_done      = (state == ST_DONE);
    assign O_timeout   = (state == ST_TMO);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized and directed bench for seg_scan_capture against a behavioural model.
module tb_seg_scan_capture;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 8;
    localparam int DATA_W = 16;
    localparam int TO_W   = 24;
`ifdef SEG_SCAN_STABLE_EN
    localparam int REPS = 2;
`else
    localparam int REPS = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic                    en;
    logic [DIGITS-1:0]       sel;
    logic [SEG_W-1:0]        seg;
    logic [DATA_W-1:0]       data;
    logic [TO_W-1:0]         to;
    logic [DIGITS*SEG_W-1:0] seg_data;
    logic [DATA_W-1:0]       disp_data;
    logic [DIGITS-1:0]       cap_mask;
    logic                    busy, done, tmo, sel_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_capture #(.DIGITS(DIGITS), .SEG_W(SEG_W), .DATA_W(DATA_W), .TO_W(TO_W)) dut (
        .I_sys_clk        (clk),
        .I_rst_n          (rst_n),
        .I_start          (start),
        .I_test_en        (en),
        .I_test_sel       (sel),
        .I_test_seg       (seg),
        .I_test_disp_data (data),
        .I_timeout        (to),
        .O_seg_data       (seg_data),
        .O_disp_data      (disp_data),
        .O_cap_mask       (cap_mask),
        .O_busy           (busy),
        .O_done           (done),
        .O_timeout        (tmo),
        .O_sel_err        (sel_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 capturing, 2 done, 3 timed out
    int               m_phase;
    bit               m_s_old, m_s_new;
    longint           m_cycles;
    bit               m_mask [DIGITS];
    logic [SEG_W-1:0] m_seg  [DIGITS];
    logic [SEG_W-1:0] m_cand [DIGITS];
    bit               m_cand_ok [DIGITS];
    logic [DATA_W-1:0] m_disp;
    bit               m_err;

    function automatic bit m_all();
        bit a = 1'b1;
        for (int k = 0; k < DIGITS; k++) a &= m_mask[k];
        return a;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < DIGITS; k++) begin
            m_mask[k] = 0; m_seg[k] = '0; m_cand[k] = '0; m_cand_ok[k] = 0;
        end
        m_disp = '0; m_err = 0; m_cycles = 0;
    endtask

    task automatic m_reset();
        m_clear();
        m_phase = 0; m_s_old = 0; m_s_new = 0;
    endtask

    task automatic m_step();
        bit pulse = !m_s_old && m_s_new;
        m_s_old = m_s_new;
        m_s_new = start;
        if (!en) begin
            m_clear(); m_phase = 0;
        end else if (pulse) begin
            m_clear(); m_phase = 1;
        end else if (m_phase == 1) begin
            bit was_full = m_all();
            int n = $countones(sel);
            if (n > 1) m_err = 1;
            if (n == 1) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (sel[k] && !m_mask[k]) begin
                        bit ok = 1;
                        if (REPS == 2) begin
                            ok = m_cand_ok[k] && (m_cand[k] == seg);
                            if (!ok) begin m_cand[k] = seg; m_cand_ok[k] = 1; end
                        end
                        if (ok) begin
                            m_mask[k] = 1; m_seg[k] = seg;
                            if (k == 0) m_disp = data;
                        end
                    end
                end
            end
            if (was_full) m_phase = 2;
            else if (to != 0 && m_cycles == longint'(to) - 1 && !m_all()) m_phase = 3;
            else if (m_cycles < (64'd1 << TO_W) - 1) m_cycles++;
        end
    endtask

    task automatic compare_all();
        logic [DIGITS*SEG_W-1:0] es;
        logic [DIGITS-1:0] em;
        for (int k = 0; k < DIGITS; k++) begin
            es[k*SEG_W +: SEG_W] = m_seg[k];
            em[k] = m_mask[k];
        end
        chk("seg_data", 64'(seg_data), 64'(es));
        chk("disp_data", 64'(disp_data), 64'(m_disp));
        chk("cap_mask", 64'(cap_mask), 64'(em));
        chk("busy", 64'(busy), 64'(m_phase == 1));
        chk("done", 64'(done), 64'(m_phase == 2));
        chk("timeout", 64'(tmo), 64'(m_phase == 3));
        chk("sel_err", 64'(sel_err), 64'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic do_sel(input logic [DIGITS-1:0] s, input logic [SEG_W-1:0] v, input logic [DATA_W-1:0] d);
        sel = s; seg = v; data = d;
        for (int r = 0; r < REPS; r++) tick();
        sel = '0;
    endtask

    task automatic full_capture();
        do_sel(4'b0001, 8'h3F, 16'h1234);
        do_sel(4'b0010, 8'h06, 16'h0000);
        do_sel(4'b0100, 8'h5B, 16'h0000);
        do_sel(4'b1000, 8'h4F, 16'h0000);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; en = 1'b0; sel = '0; seg = '0; data = '0; to = '0;
        m_reset();
        #13;
        chk("rst_seg_data", 64'(seg_data), 64'd0);
        chk("rst_cap_mask", 64'(cap_mask), 64'd0);
        chk("rst_flags", 64'({busy, done, tmo, sel_err}), 64'd0);
        chk("rst_disp", 64'(disp_data), 64'd0);
        #10 rst_n = 1'b1;
        en = 1'b1;
        tick();

        // Basic capture of all four digits
        pulse_start();
        chk("start_busy", 64'(busy), 64'd1);
        full_capture();
        chk("basic_mask", 64'(cap_mask), 64'hF);
        chk("basic_not_done_yet", 64'(done), 64'd0);
        tick();
        chk("basic_done", 64'(done), 64'd1);
        chk("basic_seg", 64'(seg_data), 64'h4F5B063F);
        chk("basic_disp", 64'(disp_data), 64'h1234);
        tick();
        chk("done_hold_seg", 64'(seg_data), 64'h4F5B063F);

        // Re-select of a captured digit must not overwrite it
        pulse_start();
        do_sel(4'b0001, 8'h3F, 16'hABCD);
        do_sel(4'b0001, 8'h00, 16'h5555);
        do_sel(4'b0001, 8'h00, 16'h5555);
        chk("resel_slot0", 64'(seg_data[7:0]), 64'h3F);
        chk("resel_disp", 64'(disp_data), 64'hABCD);
        tick();
        chk("resel_no_done", 64'(done), 64'd0);
        do_sel(4'b0010, 8'h06, 16'h0); do_sel(4'b0100, 8'h5B, 16'h0); do_sel(4'b1000, 8'h4F, 16'h0);
        tick();
        chk("resel_done", 64'(done), 64'd1);

        // Timeout after 100 capture cycles with two digits captured
        to = 24'd100;
        pulse_start();
        n = 0;
        sel = 4'b0001; seg = 8'h11;
        for (int r = 0; r < REPS; r++) begin tick(); n++; end
        sel = 4'b0010; seg = 8'h22;
        for (int r = 0; r < REPS; r++) begin tick(); n++; end
        sel = '0;
        while (!tmo && n < 300) begin tick(); n++; end
        chk("tmo_cycles", 64'(n), 64'd100);
        chk("tmo_mask", 64'(cap_mask), 64'h3);
        chk("tmo_done", 64'(done), 64'd0);
        to = '0;

        // Multi-hot select flags an error and writes nothing
        pulse_start();
        do_sel(4'b0001, 8'h3F, 16'h1234);
        sel = 4'b0110; seg = 8'hEE; tick(); sel = '0;
        chk("multi_err", 64'(sel_err), 64'd1);
        chk("multi_mask", 64'(cap_mask), 64'h1);
        do_sel(4'b0010, 8'h06, 16'h0); do_sel(4'b0100, 8'h5B, 16'h0); do_sel(4'b1000, 8'h4F, 16'h0);
        tick();
        chk("multi_done", 64'(done), 64'd1);
        chk("multi_err_sticky", 64'(sel_err), 64'd1);

        // Enable drop mid-capture clears everything, then a fresh capture succeeds
        pulse_start();
        do_sel(4'b0001, 8'h3F, 16'h1234);
        en = 1'b0; tick();
        chk("en_low_seg", 64'(seg_data), 64'd0);
        chk("en_low_flags", 64'({busy, done, tmo, sel_err, cap_mask}), 64'd0);
        en = 1'b1; tick();
        pulse_start();
        full_capture();
        tick();
        chk("en_fresh_done", 64'(done), 64'd1);
        chk("en_fresh_seg", 64'(seg_data), 64'h4F5B063F);

`ifdef SEG_SCAN_STABLE_EN
        pulse_start();
        sel = 4'b0010; seg = 8'h06; tick(); seg = 8'h5B; tick();
        chk("stab_not_yet", 64'(cap_mask[1]), 64'd0);
        tick(); sel = '0;
        chk("stab_cap", 64'(cap_mask[1]), 64'd1);
        chk("stab_val", 64'(seg_data[15:8]), 64'h5B);
        pulse_start();
        for (int k = 0; k < DIGITS; k++) begin
            sel = DIGITS'(1 << k); seg = 8'(k + 1); tick(); sel = '0; tick();
        end
        tick();
        chk("stab_single_no_done", 64'(done), 64'd0);
`endif

        // Asynchronous reset mid-capture abandons everything
        pulse_start();
        do_sel(4'b0001, 8'h3F, 16'h1234);
        rst_n = 1'b0;
        #2;
        chk("arst_seg", 64'(seg_data), 64'd0);
        chk("arst_flags", 64'({busy, done, tmo, sel_err, cap_mask}), 64'd0);
        chk("arst_disp", 64'(disp_data), 64'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i % 250 == 0) to = ($urandom_range(0, 1) == 1) ? TO_W'($urandom_range(10, 60)) : '0;
            en    = ($urandom_range(0, 59) != 0);
            start = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 9);
            if (r < 3)      sel = '0;
            else if (r < 9) sel = DIGITS'(1 << $urandom_range(0, DIGITS - 1));
            else            sel = DIGITS'($urandom);
            seg  = ($urandom_range(0, 1) == 1) ? SEG_W'($urandom_range(0, 3)) : SEG_W'($urandom);
            data = DATA_W'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
